// File: rtl/srl16_fifo_ctrl.sv
// Controller sequencing WIDTH SRL16E cells as a 16-deep shift-register FIFO
// with one registered output stage and valid/ready handshakes on both sides.
module srl16_fifo_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AF_LEVEL = 14
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] srl_d,
  output logic             srl_ce,
  output logic [3:0]       srl_addr,
  input  logic [WIDTH-1:0] srl_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       count,
  output logic             almost_full
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned DEPTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] srl_cnt_q, srl_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             almost_full_q, almost_full_d;
  logic             push;
  logic             load;

  // Next-state and handshake logic; flush overrides both push and load.
  always_comb begin
    in_ready      = CLR & ~flush & (state_q != ST_FULL);
    push          = in_valid & in_ready;
    load          = (state_q != ST_EMPTY) & (~out_valid_q | out_ready) & ~flush;
    srl_cnt_d     = srl_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    state_d       = state_q;
    count_d       = count_q;
    almost_full_d = almost_full_q;

    if (flush) begin
      srl_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      srl_cnt_d = srl_cnt_q + CNT_W'(push) - CNT_W'(load);
      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = srl_q;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    if (srl_cnt_d == '0)                state_d = ST_EMPTY;
    else if (srl_cnt_d == CNT_W'(DEPTH)) state_d = ST_FULL;
    else                                 state_d = ST_RUN;

    count_d       = srl_cnt_d + CNT_W'(out_valid_d);
    almost_full_d = (count_d >= CNT_W'(AF_LEVEL));
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q       <= ST_EMPTY;
      srl_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      srl_cnt_q     <= srl_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Oldest entry sits at tap srl_cnt-1; tap 0 when the SRL is empty.
  assign srl_addr    = (state_q == ST_EMPTY) ? 4'd0 : 4'(srl_cnt_q - CNT_W'(1));
  assign srl_ce      = push;
  assign srl_d       = in_data;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule
